// File: rtl/itoa_stream.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : itoa_stream
// Description : Streams a 32-bit integer as ASCII decimal characters, MSD first.
//               Define ITOA_SIGNED_EN for two's-complement input with a
//               leading '-'; otherwise the input is treated as unsigned.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module itoa_stream (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_div  = 2'd1;
   localparam logic [1:0] c_sign = 2'd2;
   localparam logic [1:0] c_emit = 2'd3;

   // ceil(2^35 / 10): (x * c_recip) >> 35 equals floor(x / 10) for every 32-bit x
   localparam logic [63:0] c_recip = 64'h0000_0000_CCCC_CCCD;

   logic [1:0]  r_state;
   logic [31:0] r_x;
   logic [3:0]  r_cnt;
   logic        r_neg;
   logic [3:0]  r_stack [0:9];

   logic        w_neg;
   logic [31:0] w_mag;
   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_q10;
   logic [31:0] w_rem_full;
   logic [3:0]  w_rem;
   logic [3:0]  w_top_idx;
   logic [3:0]  w_top;
   logic        w_unused_bits;

`ifdef ITOA_SIGNED_EN
   assign w_neg = in_data[31];
   assign w_mag = in_data[31] ? (~in_data + 32'd1) : in_data;
`else
   assign w_neg = 1'b0;
   assign w_mag = in_data;
`endif

   assign w_prod        = {32'd0, r_x} * c_recip;
   assign w_quot        = {3'b000, w_prod[63:35]};
   assign w_q10         = (w_quot << 3) + (w_quot << 1);
   assign w_rem_full    = r_x - w_q10;
   assign w_rem         = w_rem_full[3:0];
   assign w_unused_bits = ^{w_prod[34:0], w_rem_full[31:4]};

   assign w_top_idx = r_cnt - 4'd1;
   assign w_top     = r_stack[w_top_idx];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= c_idle;
         r_x     <= 32'd0;
         r_cnt   <= 4'd0;
         r_neg   <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (in_valid) begin
                  r_x     <= w_mag;
                  r_neg   <= w_neg;
                  r_cnt   <= 4'd0;
                  r_state <= c_div;
               end
            end
            c_div: begin
               r_cnt <= r_cnt + 4'd1;
               r_x   <= w_quot;
               if (w_quot == 32'd0) begin
                  r_state <= r_neg ? c_sign : c_emit;
               end
            end
            c_sign: begin
               if (out_ready) begin
                  r_state <= c_emit;
               end
            end
            c_emit: begin
               if (out_ready) begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     r_state <= c_idle;
                  end
               end
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   // Digit storage carries no reset: r_cnt alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (rstn && (r_state == c_div)) begin
         r_stack[r_cnt] <= w_rem;
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      case (r_state)
         c_idle: in_ready = 1'b1;
         c_sign: begin
            out_valid = 1'b1;
            out_data  = 8'h2D;
         end
         c_emit: begin
            out_valid = 1'b1;
            out_data  = {4'h3, w_top};
            out_last  = (r_cnt == 4'd1);
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_itoa_stream.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_itoa_stream
// Description : Randomized and directed self-checking bench for itoa_stream.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_itoa_stream;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_last;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   itoa_stream dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected character string straight from the decimal meaning of the value.
   function automatic string ref_str(input logic [31:0] v);
`ifdef ITOA_SIGNED_EN
      return $sformatf("%0d", $signed(v));
`else
      return $sformatf("%0d", v);
`endif
   endfunction

   // Called and returns just after a falling edge. mode: 0 ready=1, 1 toggle, 2 random.
   task automatic run_value(input logic [31:0] v, input int mode, input bit immediate,
                            input bit chain, input logic [31:0] nxt, input int abort_n);
      string s = ref_str(v);
      int    len = s.len();
      int    d = (s[0] == "-") ? len - 1 : len;
      int    waits = 0;
      int    c = 1;
      int    idx = 0;
      in_valid = 1'b1;
      in_data  = v;
      if (immediate) chk("back_to_back_ready", 32'(in_ready), 32'd1);
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      while (idx < len && c < 80) begin
         if (abort_n > 0 && idx == abort_n) begin
            in_valid = 1'b0;
            return;
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 2) == 1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         chk("busy_in_ready", 32'(in_ready), 32'd0);
         if (c <= d) begin
            chk("div_out_valid", 32'(out_valid), 32'd0);
            chk("div_out_data", 32'(out_data), 32'd0);
         end else begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("char%0d", idx), 32'(out_data), 32'(s[idx]));
            chk($sformatf("last%0d", idx), 32'(out_last), 32'(idx == len - 1));
         end
         if (mode == 2) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
         end
         if (out_ready && c > d) begin
            if (idx == len - 1) begin
               in_valid = chain;
               in_data  = nxt;
            end
            idx++;
         end
         @(negedge clk);
         c++;
      end
      if (idx < len) chk("emit_timeout", 32'(idx), 32'(len));
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_out_valid", 32'(out_valid), 32'd0);
      if (!chain) in_valid = 1'b0;
   endtask

   logic [31:0] edge_vals [0:9];

   initial begin
      logic [31:0] v;
      edge_vals[0] = 32'd0;          edge_vals[1] = 32'd9;
      edge_vals[2] = 32'd10;         edge_vals[3] = 32'd99;
      edge_vals[4] = 32'd100;        edge_vals[5] = 32'h7FFF_FFFF;
      edge_vals[6] = 32'h8000_0000;  edge_vals[7] = 32'hFFFF_FFFF;
      edge_vals[8] = 32'd1000000000; edge_vals[9] = 32'd999999999;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run_value(32'd0, 0, 1'b0, 1'b0, 32'd0, 0);
      run_value(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'd0, 0);
      run_value(32'd1234567890, 1, 1'b0, 1'b0, 32'd0, 0);
      run_value(32'h8000_0000, 0, 1'b0, 1'b0, 32'd0, 0);
      run_value(32'd10, 0, 1'b0, 1'b0, 32'd0, 0);
      run_value(32'd9, 0, 1'b0, 1'b0, 32'd0, 0);

      // Reset after the third character of a conversion.
      run_value(32'd987654321, 0, 1'b0, 1'b0, 32'd0, 3);
      rstn = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_quiet", 32'(out_valid), 32'd0);
      end
      run_value(32'd42, 0, 1'b0, 1'b0, 32'd0, 0);

      run_value(32'd7, 0, 1'b0, 1'b1, 32'd35, 0);
      run_value(32'd35, 0, 1'b1, 1'b0, 32'd0, 0);

      repeat (30) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 99);
            1:       v = $urandom;
            2:       v = edge_vals[$urandom_range(0, 9)];
            default: v = $urandom >> $urandom_range(0, 31);
         endcase
         run_value(v, int'($urandom_range(0, 2)), 1'b0, 1'b0, 32'd0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
